// File: rtl/sram_arbiter_if.sv
// Requester-side bundle of the SRAM arbiter: one CPU port and one loader port
// that share the same request/complete handshake.
interface sram_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_done;

    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic [DATA_W-1:0] ldr_rdata;
    logic              ldr_done;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_rdata, ldr_done
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_rdata, ldr_done
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one asynchronous 16-bit SRAM between the CPU
// and loader ports, with a fixed-length strobe sequence per access.
//
// state  | meaning
// IDLE   | strobes high, bus released, pick a requester
// ACCESS | CE/UB/LB low for ACCESS_CYCLES cycles, read or write in flight
// DONE   | strobes high, one-cycle done pulse to the granted port
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    sram_arbiter_if.slave     host,
    output logic              busy,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] Data
);
    localparam int CNT_W = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              gnt;          // 0 = CPU, 1 = loader
    logic              last_grant;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q, ldr_rdata_q;
    logic              grant_valid, grant_sel;
    logic              drive;
    logic              cpu_done_c, ldr_done_c;

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        grant_valid = 1'b0;
        grant_sel   = 1'b0;
        CE          = 1'b1;
        UB          = 1'b1;
        LB          = 1'b1;
        OE          = 1'b1;
        WE          = 1'b1;
        drive       = 1'b0;
        cpu_done_c  = 1'b0;
        ldr_done_c  = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (host.cpu_req && host.ldr_req) begin
                    grant_valid = 1'b1;
                    grant_sel   = ~last_grant;
                end else if (host.cpu_req || host.ldr_req) begin
                    grant_valid = 1'b1;
                    grant_sel   = host.ldr_req;
                end
                if (grant_valid) state_nxt = ACCESS;
            end
            ACCESS: begin
                CE = 1'b0;
                UB = 1'b0;
                LB = 1'b0;
                if (we_q) begin
                    drive = 1'b1;
                    // first access cycle is address setup before WE falls
                    WE    = (cnt == CNT_LOAD);
                end else begin
                    OE = 1'b0;
                end
                if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                cpu_done_c = ~gnt;
                ldr_done_c = gnt;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ADDR        <= '0;
            cnt         <= '0;
            gnt         <= 1'b0;
            last_grant  <= 1'b1;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            if (state == IDLE && grant_valid) begin
                gnt        <= grant_sel;
                last_grant <= grant_sel;
                we_q       <= grant_sel ? host.ldr_we    : host.cpu_we;
                ADDR       <= grant_sel ? host.ldr_addr  : host.cpu_addr;
                wdata_q    <= grant_sel ? host.ldr_wdata : host.cpu_wdata;
                cnt        <= CNT_LOAD;
            end
            if (state == ACCESS) begin
                if (cnt != '0) cnt <= cnt - 1'b1;
                if (cnt == '0 && !we_q) begin
                    if (gnt) ldr_rdata_q <= Data;
                    else     cpu_rdata_q <= Data;
                end
            end
        end
    end

    assign Data           = drive ? wdata_q : {DATA_W{1'bz}};
    assign host.cpu_rdata = cpu_rdata_q;
    assign host.ldr_rdata = ldr_rdata_q;
    assign host.cpu_done  = cpu_done_c;
    assign host.ldr_done  = ldr_done_c;
endmodule
